led_arbiter: RTL and testbench
==============================

LED_ARBITER -- requirements
Module: led_arbiter

Interface
REQ-001 Parameter N_REQ, default 4: number of requesters sharing the single LED.
REQ-002 Parameter TICK_DIV, default 12000: clk cycles per tick (1 ms at 12 MHz).
REQ-003 Parameters ON_TICKS / OFF_TICKS / GAP_TICKS, defaults 200 / 200 / 600: pulse-on, inter-pulse-off and trailing-gap lengths in ticks; each SHALL be >= 1.
REQ-004 clk  input  1  sole clock; all state on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 req  input  N_REQ  per-requester request level, bit i = requester i.
REQ-007 count  input  4*N_REQ  blink count for requester i at bits [4i+3:4i], 0..15.
REQ-008 gnt  output  N_REQ  one-hot grant; at most one bit set.
REQ-009 done  output  N_REQ  one-cycle completion pulse to the granted requester.
REQ-010 busy  output  1  high whenever state is not IDLE.
REQ-011 led  output  1  LED drive, active-high.

Function
REQ-012 FSM states: IDLE, ON, OFF, GAP.
REQ-013 In IDLE with any req set, the arbiter SHALL select one requester round-robin, then on the next edge set its gnt bit, latch its count and enter ON; if the latched count is 0, enter GAP instead.
REQ-014 Round-robin: after requester k is served or aborted, priority order SHALL be k+1, k+2, ... mod N_REQ; after reset requester 0 is highest.
REQ-015 The tick prescaler and the phase timer SHALL restart at every state entry, so each phase lasts exactly (phase_TICKS * TICK_DIV) cycles.
REQ-016 led SHALL be 1 in ON and 0 in every other state; led is registered.
REQ-017 ON SHALL go to OFF while pulses remain, and to GAP after the last latched pulse; OFF SHALL go to ON.
REQ-018 done[k] SHALL pulse in the final cycle of GAP; the next state is IDLE and gnt clears on that edge.
REQ-019 At least one IDLE cycle SHALL separate consecutive grants.
REQ-020 If req[k] of the granted requester falls in ON, OFF or GAP, the arbiter SHALL enter IDLE on the next edge with led 0 and gnt 0, and SHALL NOT pulse done.
REQ-021 Changes to count[k] after grant SHALL have no effect until the next grant.
REQ-022 Requests from non-granted requesters SHALL be ignored until IDLE; they are not lost while held.

Reset
REQ-023 While rst_n is low: state IDLE, gnt 0, done 0, busy 0, led 0, round-robin pointer at requester 0, prescaler and counters 0.
REQ-024 Reset asserted mid-sequence SHALL take effect immediately (asynchronous) and no done SHALL be issued.
REQ-025 After rst_n rises, the first grant SHALL occur no earlier than the second rising edge.

Structure
REQ-026 Package led_pkg SHALL hold the state enumeration, the count width constant (4) and the default N_REQ.
REQ-027 The prescaler SHALL be a sub-module led_tick (inputs clk, rst_n, clear; output tick, one-cycle pulse every TICK_DIV cycles).
REQ-028 Widths of the phase timer and pulse counter SHALL derive from the parameters via clog2.

Verification
Bench parameters: TICK_DIV=2, ON_TICKS=2, OFF_TICKS=1, GAP_TICKS=3.
REQ-029 req[0]=1 with count=3 -> led high 4 cycles, low 2, high 4, low 2, high 4, then low 6; done[0] pulses 22 cycles after gnt[0] rises.
REQ-030 req[0] and req[2] both high from reset -> requester 0 is served first, then requester 2 after at least one IDLE cycle; with req[0] still held, requester 2 precedes the second grant to 0.
REQ-031 count=0 on req[1] -> led stays 0, and done[1] pulses 6 cycles after gnt[1] rises.
REQ-032 req[3] dropped during the second ON phase -> led 0 and gnt 0 on the next edge, no done, busy 0.
REQ-033 rst_n pulsed low during OFF -> all outputs 0 immediately; the next grant goes to requester 0.
REQ-034 count[0] changed from 2 to 9 after grant -> exactly 2 pulses emitted.

Source files
------------

// File: rtl/led_pkg.sv
// Shared types and constants for the LED arbiter: FSM states, blink-count
// width and the default number of requesters.
package led_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ON   = 2'd1,
    ST_OFF  = 2'd2,
    ST_GAP  = 2'd3
  } led_state_t;

  localparam int COUNT_W   = 4;
  localparam int DEF_N_REQ = 4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/led_tick.sv
// Tick prescaler: emits a one-cycle tick every TICK_DIV clocks and restarts
// from zero whenever clear is asserted.
module led_tick #(
  parameter int TICK_DIV = 12000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [DW-1:0] cnt;

  assign tick = (cnt == DW'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_arbiter.sv
// Round-robin arbiter that lends a single LED to N_REQ requesters, blinking
// each granted requester's latched count followed by a trailing gap.
module led_arbiter
  import led_pkg::*;
#(
  parameter int N_REQ     = DEF_N_REQ,
  parameter int TICK_DIV  = 12000,
  parameter int ON_TICKS  = 200,
  parameter int OFF_TICKS = 200,
  parameter int GAP_TICKS = 600
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req,
  input  logic [COUNT_W*N_REQ-1:0]   count,
  output logic [N_REQ-1:0]           gnt,
  output logic [N_REQ-1:0]           done,
  output logic                       busy,
  output logic                       led
);

  localparam int MAXT = max3(ON_TICKS, OFF_TICKS, GAP_TICKS);
  localparam int TW   = (MAXT > 1) ? $clog2(MAXT) : 1;
  localparam int PW   = $clog2(2 ** COUNT_W);
  localparam int IW   = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  led_state_t state, state_next;

  logic [TW-1:0]      timer;
  logic [PW-1:0]      pulses;
  logic [IW-1:0]      ptr;
  logic [IW-1:0]      sel;
  logic [IW-1:0]      pick;
  logic               pick_valid;
  logic [COUNT_W-1:0] pick_count;
  logic [N_REQ-1:0]   pick_onehot;
  logic               armed;
  logic               tick;
  logic               clear;
  logic               held;
  logic               phase_end;
  int                 phase_len;

  led_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .tick  (tick)
  );

  // Round-robin search starting at ptr; the first requester found wins.
  always_comb begin
    int idx;
    idx         = 0;
    pick        = '0;
    pick_valid  = 1'b0;
    pick_count  = '0;
    pick_onehot = '0;
    for (int off = 0; off < N_REQ; off++) begin
      idx = (int'(ptr) + off) % N_REQ;
      if (!pick_valid && req[idx]) begin
        pick_valid = 1'b1;
        pick       = IW'(idx);
      end
    end
    for (int i = 0; i < N_REQ; i++) begin
      pick_onehot[i] = (pick == IW'(i));
      if (pick == IW'(i)) begin
        pick_count = count[i*COUNT_W +: COUNT_W];
      end
    end
  end

  always_comb begin
    phase_len = GAP_TICKS;
    case (state)
      ST_ON:   phase_len = ON_TICKS;
      ST_OFF:  phase_len = OFF_TICKS;
      default: phase_len = GAP_TICKS;
    endcase
  end

  assign held      = req[sel];
  assign phase_end = tick && (timer == TW'(phase_len - 1));

  // Dropping the granted request aborts from any active phase.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (armed && pick_valid) begin
          state_next = (pick_count == '0) ? ST_GAP : ST_ON;
        end
      end
      ST_ON: begin
        if (!held) begin
          state_next = ST_IDLE;
        end else if (phase_end) begin
          state_next = (pulses <= PW'(1)) ? ST_GAP : ST_OFF;
        end
      end
      ST_OFF: begin
        if (!held) begin
          state_next = ST_IDLE;
        end else if (phase_end) begin
          state_next = ST_ON;
        end
      end
      ST_GAP: begin
        if (!held || phase_end) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Prescaler and phase timer restart on every state entry and stay parked in IDLE.
  assign clear = (state_next != state) || (state == ST_IDLE);
  assign busy  = (state != ST_IDLE);

  always_comb begin
    done = '0;
    if (state == ST_GAP && phase_end && held) begin
      done = gnt;
    end
  end

  // armed holds off the first grant until the second edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      timer  <= '0;
      pulses <= '0;
      ptr    <= '0;
      sel    <= '0;
      armed  <= 1'b0;
      gnt    <= '0;
      led    <= 1'b0;
    end else begin
      armed <= 1'b1;
      state <= state_next;
      led   <= (state_next == ST_ON);
      if (clear) begin
        timer <= '0;
      end else if (tick) begin
        timer <= timer + 1'b1;
      end
      if (state == ST_IDLE && state_next != ST_IDLE) begin
        gnt    <= pick_onehot;
        sel    <= pick;
        pulses <= PW'(pick_count);
        if (int'(pick) == N_REQ - 1) begin
          ptr <= '0;
        end else begin
          ptr <= pick + 1'b1;
        end
      end else if (state_next == ST_IDLE) begin
        gnt <= '0;
      end
      if (state == ST_ON && state_next == ST_OFF) begin
        pulses <= pulses - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_led_arbiter.sv
// Scoreboard bench for led_arbiter: scenarios push expected grant outcomes,
// a negedge monitor reconstructs each grant from the pins and compares.
module tb_led_arbiter;

  localparam int N_REQ = 4;

  logic                 clk;
  logic                 rst_n;
  logic [N_REQ-1:0]     req;
  logic [4*N_REQ-1:0]   count;
  logic [N_REQ-1:0]     gnt;
  logic [N_REQ-1:0]     done;
  logic                 busy;
  logic                 led;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int kind;
    int idx;
    int lat;
    int pulses;
    int on;
  } exp_t;

  localparam int K_DONE  = 1;
  localparam int K_ABORT = 2;

  exp_t sb[$];

  led_arbiter #(
    .N_REQ     (N_REQ),
    .TICK_DIV  (2),
    .ON_TICKS  (2),
    .OFF_TICKS (1),
    .GAP_TICKS (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .count (count),
    .gnt   (gnt),
    .done  (done),
    .busy  (busy),
    .led   (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic [N_REQ-1:0] r, input logic [4*N_REQ-1:0] c);
    req   = r;
    count = c;
  endtask

  task automatic expectDone(input int idx, input int lat, input int p, input int on);
    exp_t e;
    e.kind = K_DONE; e.idx = idx; e.lat = lat; e.pulses = p; e.on = on;
    sb.push_back(e);
  endtask

  task automatic expectAbort(input int idx, input int p);
    exp_t e;
    e.kind = K_ABORT; e.idx = idx; e.lat = 0; e.pulses = p; e.on = 0;
    sb.push_back(e);
  endtask

  function automatic int idxOf(input logic [N_REQ-1:0] v);
    for (int i = 0; i < N_REQ; i++) begin
      if (v[i]) return i;
    end
    return -1;
  endfunction

  // Monitor: rebuilds each grant (latency, pulses, on-cycles) and pops the scoreboard.
  logic [N_REQ-1:0] prev_gnt = '0;
  logic             prev_led = 1'b0;
  int               cur_idx = -1;
  int               cyc = 0;
  int               pulses = 0;
  int               on_cyc = 0;
  bit               done_seen = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    checkOutput("busy_vs_gnt", int'(busy), int'(gnt != '0));
    if (gnt == '0) checkOutput("led_idle", int'(led), 0);
    if (gnt != '0 && gnt != prev_gnt) begin
      checkOutput("idle_gap", int'(prev_gnt), 0);
      checkOutput("gnt_onehot", $countones(gnt), 1);
      cur_idx   = idxOf(gnt);
      cyc       = 0;
      pulses    = 0;
      on_cyc    = 0;
      done_seen = 1'b0;
      prev_led  = 1'b0;
    end
    if (gnt != '0) begin
      cyc++;
      if (led && !prev_led) pulses++;
      if (led) on_cyc++;
    end
    if (done != '0) begin
      done_seen = 1'b1;
      if (sb.size() == 0) begin
        errors++;
        checks++;
        $display("[TB] FAIL unexpected_done: got done=%0d, expected no event", done);
      end else begin
        e = sb.pop_front();
        checkOutput("done_matches_gnt", int'(done), int'(gnt));
        checkOutput("event_kind", K_DONE, e.kind);
        checkOutput("done_idx", idxOf(done), e.idx);
        checkOutput("done_latency", cyc, e.lat);
        checkOutput("done_pulses", pulses, e.pulses);
        checkOutput("done_on_cycles", on_cyc, e.on);
      end
    end
    if (gnt == '0 && prev_gnt != '0 && !done_seen) begin
      if (sb.size() == 0) begin
        errors++;
        checks++;
        $display("[TB] FAIL unexpected_abort: got abort of %0d, expected no event", cur_idx);
      end else begin
        e = sb.pop_front();
        checkOutput("event_kind", K_ABORT, e.kind);
        checkOutput("abort_idx", cur_idx, e.idx);
        checkOutput("abort_pulses", pulses, e.pulses);
      end
    end
    prev_gnt = gnt;
    prev_led = led;
  end

  task automatic doReset(input logic [N_REQ-1:0] r, input logic [4*N_REQ-1:0] c);
    rst_n = 1'b0;
    applyStimulus(r, c);
    #1;
    checkOutput("rst_gnt", int'(gnt), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_led", int'(led), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic waitDone(input int maxc);
    bit found = 1'b0;
    for (int i = 0; i < maxc && !found; i++) begin
      @(negedge clk);
      if (done != '0) found = 1'b1;
    end
    if (!found) begin
      errors++;
      checks++;
      $display("[TB] FAIL timeout_done: got no done within %0d cycles, expected a done pulse", maxc);
    end
  endtask

  task automatic waitLed(input bit rising, input int nth, input int maxc);
    int  seen = 0;
    logic p = led;
    for (int i = 0; i < maxc && seen < nth; i++) begin
      @(negedge clk);
      if (rising ? (led && !p) : (!led && p)) seen++;
      p = led;
    end
    if (seen < nth) begin
      errors++;
      checks++;
      $display("[TB] FAIL timeout_led: got %0d edges, expected %0d", seen, nth);
    end
  endtask

  task automatic waitGnt(input int maxc);
    bit found = 1'b0;
    for (int i = 0; i < maxc && !found; i++) begin
      @(negedge clk);
      if (gnt != '0) found = 1'b1;
    end
    if (!found) begin
      errors++;
      checks++;
      $display("[TB] FAIL timeout_gnt: got no grant within %0d cycles, expected a grant", maxc);
    end
  endtask

  task automatic finishReq();
    @(posedge clk);
    #1 applyStimulus('0, '0);
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus('0, '0);

    // Three pulses: 4 on / 2 off pattern, done in the 22nd granted cycle.
    expectDone(0, 22, 3, 12);
    doReset(4'b0001, 16'h0003);
    waitDone(100);
    finishReq();

    // Requesters 0 and 2 held from reset: order 0, 2, 0; grant on second edge.
    expectDone(0, 10, 1, 4);
    expectDone(2, 16, 2, 8);
    expectDone(0, 10, 1, 4);
    doReset(4'b0101, 16'h0201);
    @(posedge clk);
    #1 checkOutput("no_grant_edge1", int'(gnt), 0);
    @(posedge clk);
    #1 checkOutput("grant_edge2", int'(gnt), 1);
    waitDone(100);
    waitDone(100);
    waitDone(100);
    finishReq();

    // Zero count: LED never lights, done after the gap alone.
    expectDone(1, 6, 0, 0);
    doReset(4'b0010, 16'h0000);
    waitDone(100);
    finishReq();

    // Requester 3 drops during its second ON phase.
    expectAbort(3, 2);
    doReset(4'b1000, 16'h4000);
    waitLed(1'b1, 2, 100);
    #2 applyStimulus('0, 16'h4000);
    @(posedge clk);
    #1;
    checkOutput("abort_led", int'(led), 0);
    checkOutput("abort_gnt", int'(gnt), 0);
    checkOutput("abort_busy", int'(busy), 0);
    checkOutput("abort_done", int'(done), 0);
    repeat (4) @(posedge clk);

    // Reset during OFF of requester 0; pointer must return to 0 afterwards.
    expectAbort(0, 1);
    expectDone(0, 10, 1, 4);
    doReset(4'b0001, 16'h0002);
    waitLed(1'b0, 1, 100);
    #2 doReset(4'b0011, 16'h0001);
    waitDone(100);
    finishReq();

    // Count changed after grant has no effect.
    expectDone(0, 16, 2, 8);
    doReset(4'b0001, 16'h0002);
    waitGnt(100);
    #2 applyStimulus(4'b0001, 16'h0009);
    waitDone(100);
    finishReq();

    repeat (5) @(posedge clk);
    checkOutput("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion by %0t, expected bench to finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
